// File: rtl/dmem_pkg.sv
// Shared constants, state encoding and helpers for the dmem_lsu data memory.
package dmem_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_e;

   // The WAIT counter is loaded with LATENCY-2, so it never holds more than that.
   function automatic int unsigned cnt_width(input int unsigned latency);
      if (latency <= 2) return 1;
      return $clog2(latency - 1);
   endfunction

   function automatic logic is_illegal(input logic we, input logic [2:0] funct3);
      if (we) return funct3[2] | (funct3[1:0] == 2'b11);
      return (funct3 == 3'b011) | (funct3[2:1] == 2'b11);
   endfunction

endpackage

// File: rtl/dmem_lsu_align.sv
// Combinational lane logic: byte-enable mask, lane-replicated store data,
// sign/zero-extended load data and the misalignment flag for one access.
module dmem_lsu_align
   import dmem_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] wdata,
   input  logic [31:0] rword,
   output logic [3:0]  byte_mask,
   output logic [31:0] wdata_lane,
   output logic [31:0] rdata_ext,
   output logic        misaligned
);

   logic [7:0]  rbyte;
   logic [15:0] rhalf;

   always_comb begin
      case (addr_lo)
         2'd0:    rbyte = rword[7:0];
         2'd1:    rbyte = rword[15:8];
         2'd2:    rbyte = rword[23:16];
         default: rbyte = rword[31:24];
      endcase
      rhalf = addr_lo[1] ? rword[31:16] : rword[15:0];
   end

   // Store data is replicated into every lane; the mask picks the live ones.
   // Halfword and word accesses ignore the low address bits, which gives the
   // force-aligned behaviour when misalignment is not trapped.
   always_comb begin
      byte_mask  = 4'b0000;
      wdata_lane = 32'h0;
      rdata_ext  = 32'h0;
      misaligned = 1'b0;
      case (funct3[1:0])
         2'b00: begin
            byte_mask  = 4'b0001 << addr_lo;
            wdata_lane = {4{wdata[7:0]}};
            rdata_ext  = funct3[2] ? {24'h0, rbyte} : {{24{rbyte[7]}}, rbyte};
         end
         2'b01: begin
            byte_mask  = addr_lo[1] ? 4'b1100 : 4'b0011;
            wdata_lane = {2{wdata[15:0]}};
            rdata_ext  = funct3[2] ? {16'h0, rhalf} : {{16{rhalf[15]}}, rhalf};
            misaligned = addr_lo[0];
         end
         2'b10: begin
            byte_mask  = 4'b1111;
            wdata_lane = wdata;
            rdata_ext  = rword;
            misaligned = |addr_lo;
         end
         default: begin
            byte_mask  = 4'b0000;
         end
      endcase
   end

endmodule

// File: rtl/dmem_lsu.sv
// RV32 data memory with a valid/ready request port and fixed response latency.
// Define DMEM_MISALIGN_TRAP_EN to report misaligned H/W accesses as errors.
module dmem_lsu
   import dmem_pkg::*;
#(
   parameter int unsigned DEPTH_WORDS = 256,
   parameter int unsigned LATENCY     = 1
)(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic [1:0]  fsm_state
);

   localparam int unsigned AW = $clog2(DEPTH_WORDS);
   localparam int unsigned CW = cnt_width(LATENCY);
   localparam logic [CW-1:0] CNT_LOAD = (LATENCY >= 2) ? CW'(LATENCY - 2) : '0;

   localparam logic [1:0] S_IDLE = 2'(IDLE);
   localparam logic [1:0] S_WAIT = 2'(WAIT);
   localparam logic [1:0] S_RESP = 2'(RESP);

`ifdef DMEM_MISALIGN_TRAP_EN
   localparam logic TRAP_EN = 1'b1;
`else
   localparam logic TRAP_EN = 1'b0;
`endif

   logic [1:0]    state;
   logic [CW-1:0] cnt;
   logic [31:0]   data_q;
   logic          err_q;
   logic [31:0]   mem [DEPTH_WORDS];

   logic [AW-1:0] idx;
   logic [31:0]   rword;
   logic [3:0]    byte_mask;
   logic [31:0]   wdata_lane;
   logic [31:0]   rdata_ext;
   logic          misaligned;
   logic          accept;
   logic          err_now;
   logic          wr_en;
   logic          unused_addr_hi;

   assign idx            = req_addr[AW+1:2];
   assign unused_addr_hi = ^req_addr[31:AW+2];
   assign rword          = mem[idx];

   dmem_lsu_align u_align (
      .funct3     (req_funct3),
      .addr_lo    (req_addr[1:0]),
      .wdata      (req_wdata),
      .rword      (rword),
      .byte_mask  (byte_mask),
      .wdata_lane (wdata_lane),
      .rdata_ext  (rdata_ext),
      .misaligned (misaligned)
   );

   assign req_ready = (state != S_WAIT);
   assign accept    = req_valid & req_ready;
   assign err_now   = is_illegal(req_we, req_funct3) | (TRAP_EN & misaligned);
   assign wr_en     = accept & req_we & ~err_now;

   // RAM is not reset, but reset still blocks a write presented on its edge.
   always_ff @(posedge clk) begin
      if (rst_n && wr_en) begin
         for (int i = 0; i < 4; i++) begin
            if (byte_mask[i]) mem[idx][8*i +: 8] <= wdata_lane[8*i +: 8];
         end
      end
   end

   // Load data is captured from the pre-write read word at the accept edge.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state  <= S_IDLE;
         cnt    <= '0;
         data_q <= 32'h0;
         err_q  <= 1'b0;
      end else begin
         case (state)
            S_IDLE, S_RESP: begin
               if (accept) begin
                  data_q <= (req_we || err_now) ? 32'h0 : rdata_ext;
                  err_q  <= err_now;
                  if (LATENCY == 1) begin
                     state <= S_RESP;
                  end else begin
                     state <= S_WAIT;
                     cnt   <= CNT_LOAD;
                  end
               end else begin
                  state <= S_IDLE;
               end
            end
            S_WAIT: begin
               if (cnt == '0) state <= S_RESP;
               else           cnt   <= cnt - 1'b1;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign rsp_valid = (state == S_RESP);
   assign rsp_rdata = rsp_valid ? data_q : 32'h0;
   assign rsp_err   = rsp_valid & err_q;
   assign fsm_state = state;

endmodule

// File: tb/tb_dmem_lsu.sv
// Bench for dmem_lsu: a LATENCY=1 instance (a) runs a vector table, a
// LATENCY=3 instance (b) runs the multi-cycle, aliasing and reset sequences.
module tb_dmem_lsu;
   import dmem_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_cmp = 0;
   int n_bad = 0;

   logic        rst_n_a, req_valid_a, req_we_a, req_ready_a, rsp_valid_a, rsp_err_a;
   logic [2:0]  req_funct3_a;
   logic [31:0] req_addr_a, req_wdata_a, rsp_rdata_a;
   logic [1:0]  fsm_state_a;

   logic        rst_n_b, req_valid_b, req_we_b, req_ready_b, rsp_valid_b, rsp_err_b;
   logic [2:0]  req_funct3_b;
   logic [31:0] req_addr_b, req_wdata_b, rsp_rdata_b;
   logic [1:0]  fsm_state_b;

   dmem_lsu #(.DEPTH_WORDS(256), .LATENCY(1)) u_dut_a (
      .clk(clk), .rst_n(rst_n_a), .req_valid(req_valid_a), .req_ready(req_ready_a),
      .req_we(req_we_a), .req_funct3(req_funct3_a), .req_addr(req_addr_a),
      .req_wdata(req_wdata_a), .rsp_valid(rsp_valid_a), .rsp_rdata(rsp_rdata_a),
      .rsp_err(rsp_err_a), .fsm_state(fsm_state_a)
   );

   dmem_lsu #(.DEPTH_WORDS(256), .LATENCY(3)) u_dut_b (
      .clk(clk), .rst_n(rst_n_b), .req_valid(req_valid_b), .req_ready(req_ready_b),
      .req_we(req_we_b), .req_funct3(req_funct3_b), .req_addr(req_addr_b),
      .req_wdata(req_wdata_b), .rsp_valid(rsp_valid_b), .rsp_rdata(rsp_rdata_b),
      .rsp_err(rsp_err_b), .fsm_state(fsm_state_b)
   );

   // Scoreboard entries: {response cycle[31:0], err, rdata[31:0]}
   logic [64:0] exp_q_a[$];
   logic [64:0] exp_q_b[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h, want 0x%08h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   always @(negedge clk) begin : mon_a
      logic [64:0] e;
      if (rsp_valid_a === 1'b1) begin
         if (exp_q_a.size() == 0) begin
            check("a unexpected rsp_valid", 32'd1, 32'd0);
         end else begin
            e = exp_q_a.pop_front();
            check("a rsp cycle", cyc, e[64:33]);
            check("a rsp_rdata", rsp_rdata_a, e[31:0]);
            check("a rsp_err", {31'h0, rsp_err_a}, {31'h0, e[32]});
         end
      end
   end

   always @(negedge clk) begin : mon_b
      logic [64:0] e;
      if (rsp_valid_b === 1'b1) begin
         if (exp_q_b.size() == 0) begin
            check("b unexpected rsp_valid", 32'd1, 32'd0);
         end else begin
            e = exp_q_b.pop_front();
            check("b rsp cycle", cyc, e[64:33]);
            check("b rsp_rdata", rsp_rdata_b, e[31:0]);
            check("b rsp_err", {31'h0, rsp_err_b}, {31'h0, e[32]});
         end
      end
   end

   task automatic drive(input bit sel, input logic v, input logic we, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd);
      if (sel) begin
         req_valid_b = v; req_we_b = we; req_funct3_b = f3; req_addr_b = a; req_wdata_b = wd;
      end else begin
         req_valid_a = v; req_we_a = we; req_funct3_a = f3; req_addr_a = a; req_wdata_a = wd;
      end
   endtask

   // Present a request, wait (bounded) for acceptance, then log the expected response.
   task automatic issue(input bit sel, input logic we, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] exp_rd, input logic exp_er,
                        input bit push, output int acc_cyc);
      int waited;
      int lat;
      logic rdy;
      waited = 0;
      lat = sel ? 3 : 1;
      @(negedge clk);
      drive(sel, 1'b1, we, f3, a, wd);
      rdy = sel ? req_ready_b : req_ready_a;
      while (rdy !== 1'b1 && waited < 20) begin
         @(negedge clk);
         waited++;
         rdy = sel ? req_ready_b : req_ready_a;
      end
      check(sel ? "b req_ready wait" : "a req_ready wait", {31'h0, rdy}, 32'd1);
      acc_cyc = cyc;
      if (push) begin
         if (sel) exp_q_b.push_back({32'(cyc + lat), exp_er, exp_rd});
         else     exp_q_a.push_back({32'(cyc + lat), exp_er, exp_rd});
      end
      @(posedge clk);
      #1;
      drive(sel, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
   endtask

   task automatic wait_drain(input bit sel);
      int n;
      n = 0;
      while ((sel ? exp_q_b.size() : exp_q_a.size()) != 0 && n < 50) begin
         @(negedge clk);
         n++;
      end
      check(sel ? "b drain" : "a drain", sel ? exp_q_b.size() : exp_q_a.size(), 32'd0);
   endtask

   typedef struct {
      logic        we;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      logic        err;
   } vec_t;

   vec_t vt[$];

   function automatic vec_t mk(input logic we, input logic [2:0] f3, input logic [31:0] a,
                               input logic [31:0] wd, input logic [31:0] rd, input logic er);
      vec_t v;
      v.we = we; v.f3 = f3; v.addr = a; v.wdata = wd; v.rdata = rd; v.err = er;
      return v;
   endfunction

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   int acc0, acc1, acc2;

   initial begin
      rst_n_a = 1'b0;
      rst_n_b = 1'b0;
      drive(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
      drive(1'b1, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
      repeat (3) @(negedge clk);

      check("a reset rsp_valid", {31'h0, rsp_valid_a}, 32'd0);
      check("a reset rsp_rdata", rsp_rdata_a, 32'd0);
      check("a reset rsp_err", {31'h0, rsp_err_a}, 32'd0);
      check("a reset req_ready", {31'h0, req_ready_a}, 32'd1);
      check("a reset state", {30'h0, fsm_state_a}, 32'(IDLE));
      check("b reset rsp_valid", {31'h0, rsp_valid_b}, 32'd0);
      check("b reset state", {30'h0, fsm_state_b}, 32'(IDLE));
      rst_n_a = 1'b1;
      rst_n_b = 1'b1;

      vt.push_back(mk(1'b1, F3_W,  32'h10, 32'hDEADBEEF, 32'h0,        1'b0));
      vt.push_back(mk(1'b0, F3_W,  32'h10, 32'h0,        32'hDEADBEEF, 1'b0));
      vt.push_back(mk(1'b1, F3_W,  32'h10, 32'h8081F0F1, 32'h0,        1'b0));
      vt.push_back(mk(1'b0, F3_B,  32'h13, 32'h0,        32'hFFFFFF80, 1'b0));
      vt.push_back(mk(1'b0, F3_BU, 32'h13, 32'h0,        32'h00000080, 1'b0));
      vt.push_back(mk(1'b0, F3_H,  32'h12, 32'h0,        32'hFFFF8081, 1'b0));
      vt.push_back(mk(1'b0, F3_HU, 32'h10, 32'h0,        32'h0000F0F1, 1'b0));
      vt.push_back(mk(1'b1, F3_W,  32'h20, 32'h0,        32'h0,        1'b0));
      vt.push_back(mk(1'b1, F3_B,  32'h21, 32'hFFFFFFAA, 32'h0,        1'b0));
      vt.push_back(mk(1'b1, F3_H,  32'h22, 32'hABCD1234, 32'h0,        1'b0));
      vt.push_back(mk(1'b0, F3_W,  32'h20, 32'h0,        32'h1234AA00, 1'b0));
      vt.push_back(mk(1'b1, F3_W,  32'h30, 32'h11223344, 32'h0,        1'b0));
      vt.push_back(mk(1'b1, 3'b011, 32'h30, 32'hFFFFFFFF, 32'h0,       1'b1));
      vt.push_back(mk(1'b1, 3'b100, 32'h30, 32'hFFFFFFFF, 32'h0,       1'b1));
      vt.push_back(mk(1'b1, 3'b111, 32'h30, 32'hFFFFFFFF, 32'h0,       1'b1));
      vt.push_back(mk(1'b0, F3_W,  32'h30, 32'h0,        32'h11223344, 1'b0));
      vt.push_back(mk(1'b0, 3'b011, 32'h30, 32'h0,       32'h0,        1'b1));
      vt.push_back(mk(1'b0, 3'b110, 32'h30, 32'h0,       32'h0,        1'b1));
      vt.push_back(mk(1'b0, 3'b111, 32'h30, 32'h0,       32'h0,        1'b1));
      vt.push_back(mk(1'b0, F3_B,  32'h30, 32'h0,        32'h00000044, 1'b0));
      vt.push_back(mk(1'b0, F3_B,  32'h31, 32'h0,        32'h00000033, 1'b0));
`ifdef DMEM_MISALIGN_TRAP_EN
      vt.push_back(mk(1'b0, F3_H,  32'h31, 32'h0,        32'h0,        1'b1));
      vt.push_back(mk(1'b1, F3_H,  32'h33, 32'h0000BEEF, 32'h0,        1'b1));
      vt.push_back(mk(1'b0, F3_H,  32'h32, 32'h0,        32'h00001122, 1'b0));
      vt.push_back(mk(1'b0, F3_HU, 32'h33, 32'h0,        32'h0,        1'b1));
      vt.push_back(mk(1'b0, F3_W,  32'h30, 32'h0,        32'h11223344, 1'b0));
      vt.push_back(mk(1'b0, F3_W,  32'h31, 32'h0,        32'h0,        1'b1));
`else
      vt.push_back(mk(1'b0, F3_H,  32'h31, 32'h0,        32'h00003344, 1'b0));
      vt.push_back(mk(1'b1, F3_H,  32'h33, 32'h0000BEEF, 32'h0,        1'b0));
      vt.push_back(mk(1'b0, F3_H,  32'h32, 32'h0,        32'hFFFFBEEF, 1'b0));
      vt.push_back(mk(1'b0, F3_HU, 32'h33, 32'h0,        32'h0000BEEF, 1'b0));
      vt.push_back(mk(1'b0, F3_W,  32'h30, 32'h0,        32'hBEEF3344, 1'b0));
      vt.push_back(mk(1'b0, F3_W,  32'h31, 32'h0,        32'hBEEF3344, 1'b0));
`endif

      foreach (vt[i]) begin
         issue(1'b0, vt[i].we, vt[i].f3, vt[i].addr, vt[i].wdata, vt[i].rdata, vt[i].err, 1'b1, acc0);
      end
      wait_drain(1'b0);

      // LATENCY=3: store via an aliased address, then a load accepted in the store's RESP cycle.
      issue(1'b1, 1'b1, F3_W, 32'h410, 32'hCAFEF00D, 32'h0, 1'b0, 1'b1, acc0);
      issue(1'b1, 1'b0, F3_W, 32'h10, 32'h0, 32'hCAFEF00D, 1'b0, 1'b1, acc1);
      check("b accept in RESP", 32'(acc1 - acc0), 32'd3);
      wait_drain(1'b1);

      issue(1'b1, 1'b0, F3_HU, 32'h12, 32'h0, 32'h0000CAFE, 1'b0, 1'b1, acc2);
      @(negedge clk);
      check("b cycle1 req_ready", {31'h0, req_ready_b}, 32'd0);
      check("b cycle1 rsp_valid", {31'h0, rsp_valid_b}, 32'd0);
      check("b cycle1 state", {30'h0, fsm_state_b}, 32'(WAIT));
      @(negedge clk);
      check("b cycle2 req_ready", {31'h0, req_ready_b}, 32'd0);
      check("b cycle2 rsp_valid", {31'h0, rsp_valid_b}, 32'd0);
      @(negedge clk);
      check("b cycle3 req_ready", {31'h0, req_ready_b}, 32'd1);
      check("b cycle3 state", {30'h0, fsm_state_b}, 32'(RESP));
      wait_drain(1'b1);

      // Reset during WAIT drops the pending load; a store on a reset edge is discarded.
      issue(1'b1, 1'b1, F3_W, 32'h40, 32'h0BADF00D, 32'h0, 1'b0, 1'b1, acc0);
      wait_drain(1'b1);
      issue(1'b1, 1'b0, F3_W, 32'h40, 32'h0, 32'h0, 1'b0, 1'b0, acc1);
      @(negedge clk);
      check("b pre-reset state", {30'h0, fsm_state_b}, 32'(WAIT));
      rst_n_b = 1'b0;
      drive(1'b1, 1'b1, 1'b1, F3_W, 32'h40, 32'hFFFFFFFF);
      @(negedge clk);
      check("b in-reset rsp_valid", {31'h0, rsp_valid_b}, 32'd0);
      check("b in-reset rsp_rdata", rsp_rdata_b, 32'd0);
      check("b in-reset rsp_err", {31'h0, rsp_err_b}, 32'd0);
      check("b in-reset state", {30'h0, fsm_state_b}, 32'(IDLE));
      @(negedge clk);
      rst_n_b = 1'b1;
      drive(1'b1, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
      repeat (4) @(negedge clk);
      issue(1'b1, 1'b0, F3_W, 32'h40, 32'h0, 32'h0BADF00D, 1'b0, 1'b1, acc2);
      wait_drain(1'b1);
      repeat (3) @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
